// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - 4-digit seven-segment scan controller
// Prescaled digit sequencer with double-buffered display word, leading-zero blanking and blink.
module disp_scan_ctrl #(
  parameter int DIV          = 131072,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load_req,
  input  logic [15:0] load_data,
  output logic        load_ack,
  input  logic        blank_lz,
  input  logic        blink_en,
  output logic [1:0]  sel,
  output logic [3:0]  digit,
  output logic [3:0]  cat,
  output logic        frame_start
);

  localparam int CW = $clog2(DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] count;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;
  logic [15:0]   active;
  logic [15:0]   shadow;
  logic          pending;

  logic          tick;
  logic          wrap;
  logic          capture;
  logic          commit;
  logic [CW-1:0] count_nx;
  logic [1:0]    sel_nx;
  logic [15:0]   active_nx;
  logic [BW-1:0] blink_cnt_nx;
  logic          blink_off_nx;
  logic          lz_nx;
  logic          dark_nx;
  logic [3:0]    digit_nx;
  logic [3:0]    cat_nx;

  always_comb begin
    tick    = enable && (count == CW'(DIV - 1));
    wrap    = tick && (sel == 2'd3);
    // A word captured while pending=0 cannot commit on the same edge, so it waits for the next wrap.
    capture = load_req && !pending && !load_ack;
    commit  = pending && (enable ? wrap : 1'b1);

    count_nx  = (!enable || tick) ? '0 : count + 1'b1;
    sel_nx    = !enable ? 2'd0 : (tick ? sel + 2'd1 : sel);
    active_nx = commit ? shadow : active;

    blink_cnt_nx = blink_cnt;
    blink_off_nx = blink_off;
    if (!blink_en) begin
      blink_cnt_nx = '0;
      blink_off_nx = 1'b0;
    end else if (wrap) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_nx = '0;
        blink_off_nx = !blink_off;
      end else begin
        blink_cnt_nx = blink_cnt + 1'b1;
      end
    end

    // Outputs are computed from next-state values so digit/cat track sel on the same edge.
    digit_nx = 4'(active_nx >> {sel_nx, 2'b00});
    case (sel_nx)
      2'd1:    lz_nx = (active_nx[15:4] == 12'h000);
      2'd2:    lz_nx = (active_nx[15:8] == 8'h00);
      2'd3:    lz_nx = (active_nx[15:12] == 4'h0);
      default: lz_nx = 1'b0;
    endcase
    dark_nx = !enable || (blink_en && blink_off_nx) || (blank_lz && lz_nx);
    cat_nx  = dark_nx ? 4'hF : ~(4'b0001 << sel_nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      sel         <= 2'd0;
      blink_cnt   <= '0;
      blink_off   <= 1'b0;
      active      <= 16'h0000;
      shadow      <= 16'h0000;
      pending     <= 1'b0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
      cat         <= 4'hF;
      digit       <= 4'h0;
    end else begin
      count       <= count_nx;
      sel         <= sel_nx;
      blink_cnt   <= blink_cnt_nx;
      blink_off   <= blink_off_nx;
      active      <= active_nx;
      load_ack    <= capture;
      frame_start <= wrap;
      cat         <= cat_nx;
      digit       <= digit_nx;
      if (capture) begin
        shadow  <= load_data;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Scan controller for the 4-digit multiplexed seven-segment display.
- Replaces the free-running ladder tap and select FSM with one programmable prescaler and one digit sequencer.
- Double-buffers the 16-bit display word behind a req/ack handshake, so keypad logic can update the display without tearing mid-frame.
- Adds leading-zero blanking and blink; the digit output feeds the hex-to-seven decoder, and sel/cat drive the mux and the digit cathodes.

Parameters:
- DIV, 131072, Clock cycles per digit slot (≥2).
- BLINK_FRAMES, 64, frames per blink half-period (≥1).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scan; 0 = display dark, sequencer parked.
- load_req  in  1  requester has a new word on load_data.
- load_data  in  16  {HEX3,HEX2,HEX1,HEX0}.
- load_ack  out  1  one-cycle pulse: load_data captured.
- blank_lz  in  1  enable leading-zero blanking.
- blink_en  in  1  enable blink.
- sel  out  2  current digit index, 0 = HEX0.
- digit  out  4  nibble of active word selected by sel.
- cat  out  4  active-low one-hot cathode enable; 1111 = all off.
- frame_start  out  1  one-cycle pulse when sel wraps 3→0.

Behaviour:
- Reset (Reset=0, async):
  - Prescaler, sel, blink counter and blink phase are 0.
  - active=0, shadow=0, pending=0.
  - load_ack=0, frame_start=0, cat=1111, digit=0.
- Prescaler:
  - Counts 0..DIV-1 while enable=1.
  - tick = (count==DIV-1); count wraps to 0 on tick.
- Slot advance, on tick:
  - sel <= sel+1, wrapping 3→0.
  - All outputs are registered: digit/cat reflect the new sel in the same clock edge.
  - One slot = DIV cycles; one frame = 4·DIV cycles.
- frame_start is 1 for exactly the cycle after the tick that moved sel 3→0.
- cat for slot n: bit n = 0 and all others 1, unless the slot is dark. A dark slot gives cat=1111, while sel and digit still advance.
- Dark conditions:
  - blink_en=1 and blink phase=off, or
  - blank_lz=1 and digit n is a leading zero. Digit k (k=3,2,1) is a leading zero iff active[4k+3:4k] and every higher nibble are 0. Digit 0 is never blanked.
- Blink:
  - Frame counter 0..BLINK_FRAMES-1 increments on each frame wrap; on its wrap, phase toggles.
  - Phase starts on (displayed).
  - blink_en=0 forces phase on and clears the counter.
- Load handshake:
  - Capture when load_req=1, pending=0 and load_ack=0 in the current cycle: shadow<=load_data, pending<=1, load_ack<=1 for one cycle.
  - The requester holds load_req/load_data until it sees ack, then drops req. If req stays high, the next capture can occur no earlier than after the commit.
  - While pending=1, load_req is stalled (no ack).
- Commit:
  - enable=1: active<=shadow, pending<=0 on the 3→0 wrap tick.
  - Capture and wrap in the same cycle: a pending=0 capture does not commit on that wrap. It waits for the next wrap.
  - enable=0: commit occurs the cycle after capture, since no scan is in progress.
- enable=0:
  - Prescaler and sel forced to 0; cat=1111; blink counter held; frame_start=0.
  - Handshake still operates.
- enable 0→1: the first tick occurs DIV cycles later, with slot 0 displayed from the first enabled cycle.
- Reset mid-operation: every register returns to its reset value, and any pending/captured word is discarded.

Test Plan (DIV=4, BLINK_FRAMES=2):
- Reset, enable=1, load 0x1234 → load_ack pulse; after first wrap, digit sequence 4,3,2,1 with cat 1110,1101,1011,0111, each held 4 cycles; frame_start every 16 cycles.
- Load 0xAAAA mid-frame at sel=1 → digit stays on old word until wrap, then all 0xA. Second req during pending → no ack until the cycle after commit.
- blank_lz=1, word 0x0050 → slots 3,2 cat=1111, slot 1 digit 5, slot 0 digit 0 shown. Word 0x0000 → only slot 0 lit.
- blink_en=1 → 2 frames lit, 2 frames all cat=1111, repeating. blink_en=0 mid-dark → next slot lit.
- enable=0 → cat=1111, sel=0 immediately; load 0xBEEF commits next cycle. Re-enable → slot 0 shows F.
- Reset low mid-frame with pending=1 → all outputs return to their reset values asynchronously (cat=1111, sel=0); after release, active=0.
